// File: rtl/ram_responder.sv
// Single-port 32-bit word RAM behind a FREE/BUSY/ACCESS/ERROR handshake; ACCESS lands LAT cycles after a valid request is first presented.
// The requester holds its request until ACCESS; any change while BUSY aborts and restarts, with no memory side effect.
module ram_responder #(
  parameter int DEPTH = 1024,
  parameter int LAT   = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [32:0] LIMIT    = 33'(4 * DEPTH);
  localparam logic [3:0]  CNT_INIT = (LAT > 1) ? 4'(LAT - 2) : 4'd0;

  typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} state_t;

  state_t        state, nxt_state;
  logic [3:0]    cnt, nxt_cnt;
  logic          cap_wen;
  logic [31:0]   cap_addr, cap_data;
  logic [31:0]   mem [DEPTH];
  logic          req_none, req_bad, match, capture, go_access;
  logic [AW-1:0] idx;

  assign ramstate = state;
  assign idx      = ramaddr[AW+1:2];
  assign req_none = !ramREN && !ramWEN;
  assign req_bad  = (ramREN && ramWEN) || (ramaddr[1:0] != 2'b00) || ({1'b0, ramaddr} >= LIMIT);
  assign match    = (ramWEN == cap_wen) && (ramREN == !cap_wen) &&
                    (ramaddr == cap_addr) && (ramstore == cap_data);

  // A held request that matches the capture simply counts down; anything else is a fresh request.
  always_comb begin
    nxt_state = FREE;
    nxt_cnt   = cnt;
    capture   = 1'b0;
    go_access = 1'b0;
    if (state == BUSY && match) begin
      if (cnt != 4'd0) begin
        nxt_state = BUSY;
        nxt_cnt   = cnt - 4'd1;
      end else begin
        nxt_state = ACCESS;
        go_access = 1'b1;
      end
    end else if (req_none) begin
      nxt_state = FREE;
    end else if (req_bad) begin
      nxt_state = ERROR;
    end else begin
      capture = 1'b1;
      if (LAT == 1) begin
        nxt_state = ACCESS;
        go_access = 1'b1;
      end else begin
        nxt_state = BUSY;
        nxt_cnt   = CNT_INIT;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= FREE;
      cnt      <= 4'd0;
      ramload  <= 32'd0;
      cap_wen  <= 1'b0;
      cap_addr <= 32'd0;
      cap_data <= 32'd0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      if (capture) begin
        cap_wen  <= ramWEN;
        cap_addr <= ramaddr;
        cap_data <= ramstore;
      end
      if (go_access && !ramWEN)
        ramload <= mem[idx];
    end
  end

  // Memory is deliberately outside the reset domain; reset only suppresses the commit.
  always_ff @(posedge CLK) begin
    if (!RST && go_access && ramWEN)
      mem[idx] <= ramstore;
  end
endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: directed scenarios with literal pins plus randomized traffic against a run-length model.
module tb_ram_responder;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ren, wen;
  logic [31:0] addr, data;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  int tests = 0;
  int fails = 0;

  ram_responder #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .CLK(clk), .RST(rst), .ramREN(ren), .ramWEN(wen),
    .ramaddr(addr), .ramstore(data), .ramload(ramload), .ramstate(ramstate)
  );

  always #5 clk = ~clk;

  // Model: a valid request held identically for k consecutive cycles reaches ACCESS whenever k is a multiple of LAT.
  logic [31:0] mm [DEPTH];
  bit          known [DEPTH];
  logic [1:0]  exp_state;
  logic [31:0] exp_load;
  bit          load_known;
  bit          chk_en = 1'b0;
  int          run = 0;
  logic [65:0] prev_sig;
  logic [31:0] pre [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [65:0] sig;
    int          i;
    sig = {ren, wen, addr, data};
    i   = int'(addr[11:2]);
    if (rst) begin
      run = 0; exp_state = 2'd0; exp_load = 32'd0; load_known = 1'b1;
    end else if (!ren && !wen) begin
      run = 0; exp_state = 2'd0;
    end else if ((ren && wen) || addr[1:0] != 2'b00 || addr >= 32'(4 * DEPTH)) begin
      run = 0; exp_state = 2'd3;
    end else begin
      run = (run > 0 && sig == prev_sig) ? run + 1 : 1;
      prev_sig = sig;
      if (run % LAT == 0) begin
        exp_state = 2'd2;
        if (wen) begin
          mm[i] = data; known[i] = 1'b1;
        end else begin
          exp_load = mm[i]; load_known = known[i];
        end
      end else begin
        exp_state = 2'd1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    ren = r; wen = w; addr = a; data = d;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("state", {30'd0, ramstate}, {30'd0, exp_state});
      if (load_known) check("ramload", ramload, exp_load);
    end
  end

  initial begin
    int r;
    for (int k = 0; k < DEPTH; k++) known[k] = 1'b0;
    rst = 1'b1;
    set_req(0, 0, 32'd0, 32'd0);
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_state", {30'd0, ramstate}, 32'd0);
    check("rst_load", ramload, 32'd0);

    for (int k = 0; k < 64; k++) begin
      pre[k] = $urandom;
      set_req(0, 1, 32'(k * 4), pre[k]);
      repeat (LAT) tick();
    end
    set_req(0, 0, 32'd0, 32'd0); tick();

    // Write then read of 0x40
    set_req(0, 1, 32'h40, 32'hDEADBEEF);
    check("w40_c0", {30'd0, ramstate}, 32'd0); tick();
    check("w40_c1", {30'd0, ramstate}, 32'd1); tick();
    check("w40_c2", {30'd0, ramstate}, 32'd2);
    set_req(1, 0, 32'h40, 32'd0); tick();
    check("r40_busy", {30'd0, ramstate}, 32'd1); tick();
    check("r40_acc", {30'd0, ramstate}, 32'd2);
    check("r40_load", ramload, 32'hDEADBEEF);

    // Address change during BUSY restarts the read
    set_req(0, 0, 32'd0, 32'd0); tick();
    set_req(1, 0, 32'h44, 32'd0); tick();
    set_req(1, 0, 32'h48, 32'd0); tick();
    check("chg_busy", {30'd0, ramstate}, 32'd1); tick();
    check("chg_acc", {30'd0, ramstate}, 32'd2);
    check("chg_load", ramload, pre[18]);

    // Simultaneous read+write is an error and leaves memory alone
    set_req(0, 0, 32'd0, 32'd0); tick();
    set_req(1, 1, 32'h40, 32'h12345678); tick();
    check("rw_err1", {30'd0, ramstate}, 32'd3); tick();
    check("rw_err2", {30'd0, ramstate}, 32'd3);
    set_req(1, 0, 32'h40, 32'd0); tick(); tick();
    check("rw_acc", {30'd0, ramstate}, 32'd2);
    check("rw_load", ramload, 32'hDEADBEEF);

    // Out-of-range and misaligned addresses
    set_req(0, 0, 32'd0, 32'd0); tick();
    set_req(1, 0, 32'h1000, 32'd0); tick();
    check("oor_err", {30'd0, ramstate}, 32'd3);
    check("oor_load", ramload, 32'hDEADBEEF);
    set_req(1, 0, 32'h41, 32'd0); tick();
    check("mis_err", {30'd0, ramstate}, 32'd3);
    check("mis_load", ramload, 32'hDEADBEEF);

    // Reset during a BUSY write drops the write
    set_req(0, 0, 32'd0, 32'd0); tick();
    set_req(0, 1, 32'h80, 32'hCAFEF00D); tick();
    check("rstw_busy", {30'd0, ramstate}, 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rstw_free", {30'd0, ramstate}, 32'd0);
    check("rstw_load", ramload, 32'd0);
    set_req(0, 0, 32'd0, 32'd0); tick();
    set_req(1, 0, 32'h80, 32'd0); tick(); tick();
    check("rstw_acc", {30'd0, ramstate}, 32'd2);
    check("rstw_rd", ramload, pre[32]);

    // Held read repeats back-to-back
    set_req(0, 0, 32'd0, 32'd0); tick();
    set_req(1, 0, 32'h40, 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k < 4) begin
        check($sformatf("hold_s%0d", k), {30'd0, ramstate}, (k % 2 == 0) ? 32'd1 : 32'd2);
        if (k % 2 == 1) check($sformatf("hold_l%0d", k), ramload, 32'hDEADBEEF);
      end
    end

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      rst = 1'b0;
      if (r < 60) begin
        // hold current request
      end else if (r < 68) set_req(0, 0, $urandom, $urandom);
      else if (r < 80) set_req(1, 0, {24'd0, 6'($urandom_range(0, 63)), 2'b00}, data);
      else if (r < 90) set_req(0, 1, {24'd0, 6'($urandom_range(0, 63)), 2'b00}, $urandom);
      else if (r < 94) set_req(1, 1, {24'd0, 6'($urandom_range(0, 63)), 2'b00}, $urandom);
      else if (r < 96) set_req(1, 0, {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))}, data);
      else if (r < 98) set_req(0, 1, 32'h1000 + 32'($urandom_range(0, 4095)) * 4, $urandom);
      else rst = 1'b1;
      tick();
    end
    rst = 1'b0;
    set_req(0, 0, 32'd0, 32'd0);
    tick();
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
